// File: rtl/multi_serial_pkg.sv
// Shared constants for the multi-port serial hub: global register offsets and coalescer states.
package multi_serial_pkg;

  localparam int unsigned PORT_NUM_MAX = 16;

  localparam logic [6:0] IPEND_LO     = 7'h00;
  localparam logic [6:0] IPEND_HI     = 7'h01;
  localparam logic [6:0] IMASK_LO     = 7'h02;
  localparam logic [6:0] IMASK_HI     = 7'h03;
  localparam logic [6:0] HOLDOFF_LO   = 7'h04;
  localparam logic [6:0] HOLDOFF_HI   = 7'h05;
  localparam logic [6:0] PORT_NUM_REG = 7'h06;
  localparam logic [6:0] FSM_STATE    = 7'h07;
  localparam logic [6:0] IRQCNT_LO    = 7'h08;
  localparam logic [6:0] IRQCNT_HI    = 7'h09;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StFire = 2'd2
  } irq_state_e;

endpackage

// File: rtl/multi_serial_irq_coalesce.sv
// Interrupt hold-off FSM: delays irq by a programmable count after activity appears.
// MULTI_SERIAL_HUB_STATS_EN adds a saturating count of FIRE entries.
module multi_serial_irq_coalesce
  import multi_serial_pkg::*;
#(
  parameter int unsigned HOLDOFF_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 act_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
`ifdef MULTI_SERIAL_HUB_STATS_EN
  input  logic                 irqcnt_clr_i,
  output logic [15:0]          irqcnt_o,
`endif
  output logic                 irq_o,
  output irq_state_e           state_o
);

  irq_state_e           state_q;
  logic [HOLDOFF_W-1:0] cnt_q;
  logic                 irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (act_i) begin
            if (holdoff_i == '0) begin
              state_q <= StFire;
              irq_q   <= 1'b1;
            end else begin
              // Count is latched here so later HOLDOFF writes do not disturb it.
              state_q <= StHold;
              cnt_q   <= holdoff_i;
            end
          end
        end
        StHold: begin
          if (!act_i) begin
            state_q <= StIdle;
          end else if (cnt_q == HOLDOFF_W'(1)) begin
            state_q <= StFire;
            irq_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - HOLDOFF_W'(1);
          end
        end
        StFire: begin
          if (!act_i) begin
            state_q <= StIdle;
            irq_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_o   = irq_q;
  assign state_o = state_q;

`ifdef MULTI_SERIAL_HUB_STATS_EN
  logic        fire_enter;
  logic [15:0] irqcnt_q;

  assign fire_enter = act_i && (((state_q == StIdle) && (holdoff_i == '0)) ||
                                ((state_q == StHold) && (cnt_q == HOLDOFF_W'(1))));

  always_ff @(posedge clk_i) begin
    if (rst_i || irqcnt_clr_i) begin
      irqcnt_q <= '0;
    end else if (fire_enter && (irqcnt_q != 16'hFFFF)) begin
      irqcnt_q <= irqcnt_q + 16'd1;
    end
  end

  assign irqcnt_o = irqcnt_q;
`endif

endmodule

// File: rtl/multi_serial_hub.sv
// Byte-bus fan-out to PORT_NUM UART register blocks plus a global interrupt register block.
// Build option MULTI_SERIAL_HUB_STATS_EN exposes an IRQ counter at global 0x08/0x09.
module multi_serial_hub
  import multi_serial_pkg::*;
#(
  parameter int unsigned PORT_NUM  = 8,
  parameter int unsigned PORT_AW   = 3,
  parameter int unsigned HOLDOFF_W = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [7:0]              wb_adr_i,
  input  logic [7:0]              wb_dat_i,
  input  logic                    wb_we_i,
  input  logic                    wb_re_i,
  output logic [7:0]              wb_dat_o,
  output logic                    wb_ack_o,
  output logic [PORT_AW-1:0]      port_adr_o,
  output logic [7:0]              port_dat_o,
  output logic [PORT_NUM-1:0]     port_we_o,
  output logic [PORT_NUM-1:0]     port_re_o,
  input  logic [8*PORT_NUM-1:0]   port_dat_i,
  input  logic [PORT_NUM-1:0]     port_int_i,
  output logic                    irq_o
);

  localparam int unsigned IdxW     = 7 - PORT_AW;
  localparam logic [15:0] PortMask = 16'((32'd1 << PORT_NUM) - 32'd1);

  logic                 is_glb, rd_stb, glb_we, act;
  logic [IdxW-1:0]      idx;
  logic [6:0]           goff;
  logic [7:0]           port_rdata, glb_rdata, rd_data;
  logic [7:0]           wb_dat_q;
  logic                 wb_ack_q;
  logic [15:0]          ipend_q, ipend_d, imask_q, imask_d, w1c;
  logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
  logic [15:0]          holdoff16, holdoff16_d;
  irq_state_e           irq_state;

  assign is_glb     = wb_adr_i[7];
  assign idx        = wb_adr_i[6:PORT_AW];
  assign goff       = wb_adr_i[6:0];
  assign rd_stb     = wb_re_i & ~wb_we_i;  // write wins a simultaneous strobe
  assign glb_we     = wb_we_i & is_glb;
  assign port_adr_o = wb_adr_i[PORT_AW-1:0];
  assign port_dat_o = wb_dat_i;
  assign holdoff16  = 16'(holdoff_q);

  always_comb begin
    port_we_o  = '0;
    port_re_o  = '0;
    port_rdata = 8'h00;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (!is_glb && (idx == IdxW'(i))) begin
        port_we_o[i] = wb_we_i;
        port_re_o[i] = rd_stb;
        port_rdata   = port_dat_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    w1c         = '0;
    imask_d     = imask_q;
    holdoff16_d = holdoff16;
    if (glb_we) begin
      case (goff)
        IPEND_LO:   w1c[7:0]          = wb_dat_i;
        IPEND_HI:   w1c[15:8]         = wb_dat_i;
        IMASK_LO:   imask_d[7:0]      = wb_dat_i;
        IMASK_HI:   imask_d[15:8]     = wb_dat_i;
        HOLDOFF_LO: holdoff16_d[7:0]  = wb_dat_i;
        HOLDOFF_HI: holdoff16_d[15:8] = wb_dat_i;
        default: ;
      endcase
    end
    // A new interrupt in the same cycle as its W1C keeps the bit set.
    ipend_d   = ((ipend_q & ~w1c) | 16'(port_int_i)) & PortMask;
    holdoff_d = holdoff16_d[HOLDOFF_W-1:0];
  end

`ifdef MULTI_SERIAL_HUB_STATS_EN
  logic [15:0] irqcnt;
`endif

  always_comb begin
    glb_rdata = 8'h00;
    case (goff)
      IPEND_LO:     glb_rdata = ipend_q[7:0];
      IPEND_HI:     glb_rdata = ipend_q[15:8];
      IMASK_LO:     glb_rdata = imask_q[7:0] & PortMask[7:0];
      IMASK_HI:     glb_rdata = imask_q[15:8] & PortMask[15:8];
      HOLDOFF_LO:   glb_rdata = holdoff16[7:0];
      HOLDOFF_HI:   glb_rdata = holdoff16[15:8];
      PORT_NUM_REG: glb_rdata = 8'(PORT_NUM);
      FSM_STATE:    glb_rdata = {irq_state, 6'b0};
`ifdef MULTI_SERIAL_HUB_STATS_EN
      IRQCNT_LO:    glb_rdata = irqcnt[7:0];
      IRQCNT_HI:    glb_rdata = irqcnt[15:8];
`endif
      default:      glb_rdata = 8'h00;
    endcase
    rd_data = is_glb ? glb_rdata : port_rdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wb_dat_q  <= 8'h00;
      wb_ack_q  <= 1'b0;
      ipend_q   <= '0;
      imask_q   <= 16'hFFFF;
      holdoff_q <= '0;
    end else begin
      wb_ack_q  <= wb_we_i | wb_re_i;
      if (rd_stb) wb_dat_q <= rd_data;
      ipend_q   <= ipend_d;
      imask_q   <= imask_d;
      holdoff_q <= holdoff_d;
    end
  end

  assign wb_dat_o = wb_dat_q;
  assign wb_ack_o = wb_ack_q;
  assign act      = |(ipend_q & imask_q);

  multi_serial_irq_coalesce #(
    .HOLDOFF_W(HOLDOFF_W)
  ) u_coalesce (
    .clk_i        (aclk),
    .rst_i        (areset),
    .act_i        (act),
    .holdoff_i    (holdoff_q),
`ifdef MULTI_SERIAL_HUB_STATS_EN
    .irqcnt_clr_i (glb_we && (goff == IRQCNT_LO)),
    .irqcnt_o     (irqcnt),
`endif
    .irq_o        (irq_o),
    .state_o      (irq_state)
  );

endmodule

// File: tb/tb_multi_serial_hub.sv
// Scoreboard bench for multi_serial_hub built with 6 ports so that index 6 is out of range.
module tb_multi_serial_hub;

  localparam int unsigned PN = 6;

  logic          aclk = 1'b0;
  logic          areset;
  logic [7:0]    wb_adr_i, wb_dat_i, wb_dat_o;
  logic          wb_we_i, wb_re_i, wb_ack_o;
  logic [2:0]    port_adr_o;
  logic [7:0]    port_dat_o;
  logic [PN-1:0] port_we_o, port_re_o, port_int_i;
  logic [8*PN-1:0] port_dat_i;
  logic          irq_o;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  always #5 aclk = ~aclk;

  multi_serial_hub #(
    .PORT_NUM  (PN),
    .PORT_AW   (3),
    .HOLDOFF_W (16)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_we_i    (wb_we_i),
    .wb_re_i    (wb_re_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .port_adr_o (port_adr_o),
    .port_dat_o (port_dat_o),
    .port_we_o  (port_we_o),
    .port_re_o  (port_re_o),
    .port_dat_i (port_dat_i),
    .port_int_i (port_int_i),
    .irq_o      (irq_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every ack pops one scoreboard entry; bit 8 says whether data is checked.
  always @(negedge aclk) begin
    if (!areset && wb_ack_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (e[8]) check("rdata", 32'(wb_dat_o), 32'(e[7:0]));
      end
    end
  end

  task automatic access(input logic we, input logic re, input logic [7:0] a, input logic [7:0] d,
                        input logic [PN-1:0] iv, input logic [PN-1:0] ewe,
                        input logic [PN-1:0] ere, input logic chk, input logic [7:0] ed);
    @(posedge aclk); #1;
    wb_adr_i = a; wb_dat_i = d; wb_we_i = we; wb_re_i = re; port_int_i = iv;
    exp_q.push_back({chk, ed});
    #1;
    check("port_we", 32'(port_we_o), 32'(ewe));
    check("port_re", 32'(port_re_o), 32'(ere));
    check("port_adr", 32'(port_adr_o), 32'(a[2:0]));
    check("port_dat", 32'(port_dat_o), 32'(d));
    @(posedge aclk); #1;
    wb_we_i = 1'b0; wb_re_i = 1'b0; port_int_i = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [PN-1:0] ewe);
    access(1'b1, 1'b0, a, d, '0, ewe, '0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] ed, input logic [PN-1:0] ere);
    access(1'b0, 1'b1, a, 8'h00, '0, '0, ere, 1'b1, ed);
  endtask

  task automatic pulse_int(input logic [PN-1:0] v);
    @(posedge aclk); #1 port_int_i = v;
    @(posedge aclk); #1 port_int_i = '0;
  endtask

  task automatic irq_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge aclk);
      if (irq_o) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_re_i = 1'b0;
    port_int_i = '0;
    for (int i = 0; i < PN; i++) port_dat_i[8*i +: 8] = 8'h10 + 8'(i);
    port_dat_i[47:40] = 8'hA5;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat", 32'(wb_dat_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);

    // Global block after reset
    rd(8'h80, 8'h00, '0);
    rd(8'h82, 8'h3F, '0);
    rd(8'h83, 8'h00, '0);
    rd(8'h84, 8'h00, '0);
    rd(8'h86, 8'd6, '0);
    rd(8'h87, 8'h00, '0);

    // Port accesses
    rd(8'h2A, 8'hA5, 6'h20);
    rd(8'h08, 8'h11, 6'h02);
    wr(8'h0B, 8'h5C, 6'h02);
    wr(8'h30, 8'h77, 6'h00);
    rd(8'h30, 8'h00, 6'h00);
    access(1'b1, 1'b1, 8'h18, 8'h3C, '0, 6'h08, 6'h00, 1'b0, 8'h00);
    rd(8'h8A, 8'h00, '0);
    wr(8'h8A, 8'hFF, '0);
    rd(8'h8A, 8'h00, '0);

    // HOLDOFF=0: pulse on port 2
    @(posedge aclk); #1 port_int_i = 6'h04;
    @(negedge aclk);
    @(posedge aclk); #1 port_int_i = '0;
    @(negedge aclk);
    check("irq_before_fire", 32'(irq_o), 32'd0);
    @(negedge aclk);
    check("irq_fire_h0", 32'(irq_o), 32'd1);
    rd(8'h80, 8'h04, '0);
    rd(8'h87, 8'h80, '0);
    wr(8'h80, 8'h04, '0);
    @(negedge aclk); @(negedge aclk);
    check("irq_w1c_drop", 32'(irq_o), 32'd0);
    rd(8'h80, 8'h00, '0);

    // HOLDOFF register byte access
    wr(8'h85, 8'h12, '0);
    rd(8'h85, 8'h12, '0);
    wr(8'h85, 8'h00, '0);
    wr(8'h84, 8'h0A, '0);
    rd(8'h84, 8'h0A, '0);

    // HOLDOFF=10, interrupt held: irq 11 cycles after act
    @(posedge aclk); #1 port_int_i = 6'h02;
    @(negedge aclk);
    n = 0;
    while (n < 40) begin
      @(negedge aclk);
      n++;
      if (irq_o) break;
    end
    check("holdoff_latency", 32'(n), 32'd12);
    @(posedge aclk); #1 port_int_i = '0;
    wr(8'h80, 8'h02, '0);
    @(negedge aclk); @(negedge aclk);
    check("irq_drop_held", 32'(irq_o), 32'd0);

    // Pulse then clear during HOLD: no irq
    pulse_int(6'h02);
    rd(8'h87, 8'h40, '0);
    wr(8'h80, 8'h02, '0);
    irq_quiet("hold_abort_irq", 20);
    rd(8'h87, 8'h00, '0);

    // Masking
    wr(8'h84, 8'h00, '0);
    wr(8'h82, 8'hFE, '0);
    pulse_int(6'h01);
    irq_quiet("masked_irq", 6);
    rd(8'h80, 8'h01, '0);
    rd(8'h82, 8'h3E, '0);
    wr(8'h82, 8'hFF, '0);
    @(negedge aclk); @(negedge aclk);
    check("unmask_irq", 32'(irq_o), 32'd1);
    rd(8'h82, 8'h3F, '0);
    wr(8'h82, 8'h00, '0);
    @(negedge aclk); @(negedge aclk);
    check("mask_all_irq", 32'(irq_o), 32'd0);
    wr(8'h80, 8'h01, '0);
    wr(8'h82, 8'hFF, '0);
    rd(8'h80, 8'h00, '0);

    // Set and W1C of IPEND[3] in the same cycle: set wins
    access(1'b1, 1'b0, 8'h80, 8'h08, 6'h08, '0, '0, 1'b0, 8'h00);
    rd(8'h80, 8'h08, '0);
    wr(8'h80, 8'h08, '0);
    rd(8'h80, 8'h00, '0);

    // Reset in the middle of HOLD
    wr(8'h84, 8'h0A, '0);
    wr(8'h82, 8'h00, '0);
    wr(8'h82, 8'hFF, '0);
    pulse_int(6'h10);
    rd(8'h87, 8'h40, '0);
    @(posedge aclk); #1 areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    check("rst_mid_irq", 32'(irq_o), 32'd0);
    check("rst_mid_ack", 32'(wb_ack_o), 32'd0);
    rd(8'h87, 8'h00, '0);
    rd(8'h82, 8'h3F, '0);
    rd(8'h80, 8'h00, '0);
    rd(8'h84, 8'h00, '0);
    irq_quiet("rst_mid_quiet", 15);

    repeat (3) @(negedge aclk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_serial_hub.md
Name: multi_serial_hub

Overview:
Parametrised successor to the fixed 8-port serial fan-out. It sits between the AXI-to-byte-bus bridge and N UART register instances. It decodes the byte-bus address to one of up to 16 ports, or to a global register block. It returns registered read data with an explicit ack, and aggregates the per-port interrupts through a sticky pending register, a mask register and a hold-off (coalescing) timer.

Parameters:
PORT_NUM, 8, number of UART ports (1..16)
PORT_AW, 3, register-offset bits per port (port stride = 2^PORT_AW bytes); PORT_AW + 4 <= 7
HOLDOFF_W, 16, width of interrupt hold-off counter/register (8..16)

Ports:
aclk  in  1  single clock
areset  in  1  synchronous, active-high reset
wb_adr_i  in  8  byte address; bit7=1 global block, else port = adr[6:PORT_AW], offset = adr[PORT_AW-1:0]
wb_dat_i  in  8  write data
wb_we_i  in  1  one-cycle write strobe
wb_re_i  in  1  one-cycle read strobe
wb_dat_o  out  8  registered read data
wb_ack_o  out  1  one-cycle ack for every strobe
port_adr_o  out  PORT_AW  shared register offset to all ports
port_dat_o  out  8  shared write data
port_we_o  out  PORT_NUM  per-port write strobe
port_re_o  out  PORT_NUM  per-port read strobe
port_dat_i  in  8*PORT_NUM  per-port read data, port i at [8i+7:8i]
port_int_i  in  PORT_NUM  per-port level interrupt
irq_o  out  1  coalesced interrupt

Behaviour:
- Clock and reset: aclk; areset is synchronous and active-high. Reset clears wb_dat_o, wb_ack_o, irq_o, IPEND and FSM (IDLE). IMASK resets to all ones (legacy OR behaviour). HOLDOFF resets to 0.
- Port access: port_adr_o/port_dat_o are combinational copies of wb_adr_i/wb_dat_i. port_we_o[i]/port_re_o[i] = strobe & (bit7==0) & (index==i), combinational, same cycle.
- Read latency 1: wb_dat_o is registered at the end of the strobe cycle, from port_dat_i[index] or the global register. wb_ack_o is high the next cycle for exactly 1 cycle.
- Writes: ack 1 cycle later. Global registers update on the clock edge ending the strobe cycle.
- Index >= PORT_NUM, or an undefined global offset: no port strobes, reads return 0x00, writes are ignored, ack is still given.
- we and re in the same cycle: write is performed, read is ignored, single ack.
- Global map (bit7=1, offsets):
  - 0x00/0x01: IPEND[7:0]/[15:8], W1C.
  - 0x02/0x03: IMASK.
  - 0x04/0x05: HOLDOFF low/high; bits above HOLDOFF_W read 0.
  - 0x06: RO PORT_NUM.
  - 0x07: RO {FSM state[1:0], 6'b0}.
  - Bits for ports >= PORT_NUM read 0 and ignore writes.
- IPEND[i] sets on any cycle port_int_i[i]=1 (level-sticky). W1C clears the bit. If set and clear happen in the same cycle, set wins.
- act = |(IPEND & IMASK), registered into the FSM.
- Coalescing FSM:
  - IDLE: if act and HOLDOFF==0 go to FIRE; if act and HOLDOFF!=0, load cnt=HOLDOFF and go to HOLD.
  - HOLD: cnt decrements each cycle. If !act, return to IDLE with no irq. At cnt==1, go to FIRE.
  - FIRE: irq_o=1, registered. If !act, go to IDLE and irq_o drops the next cycle.
- HOLDOFF written during HOLD affects only the next HOLD entry; the running count is unaffected.
- Latency act->irq_o: 1 cycle with HOLDOFF=0; HOLDOFF+1 cycles otherwise.
- Masking all bits while in FIRE clears irq_o within 2 cycles.

Optional Feature:
MULTI_SERIAL_HUB_STATS_EN
- Defined: adds a 16-bit saturating IRQCNT, incremented on each IDLE/HOLD->FIRE transition, readable at global 0x08/0x09. Any write to 0x08 clears it. If increment and clear happen in the same cycle, clear wins.
- Undefined: 0x08/0x09 read 0x00, no counter logic.

Decomposition:
- Package multi_serial_pkg holds:
  - global offset constants (IPEND_LO..IRQCNT_HI)
  - FSM state encoding: IDLE=2'd0, HOLD=2'd1, FIRE=2'd2
  - PORT_NUM_MAX=16
- Sub-module multi_serial_irq_coalesce holds the FSM, counter and optional stats counter. Inputs: act, holdoff. Outputs: irq, state.

Test Plan:
- Read port 5 offset 2 (adr=0x2A), port_dat_i[47:40]=0xA5 -> port_re_o=0x20 in same cycle; next cycle wb_ack_o=1, wb_dat_o=0xA5.
- PORT_NUM=4, write adr=0x30 -> no port_we_o, ack given; read returns 0x00.
- HOLDOFF=0, port_int_i[2] pulses 1 cycle -> IPEND=0x0004, irq_o high after 1 cycle. W1C 0x04 to 0x80 -> irq_o low within 2 cycles.
- HOLDOFF=10, int held -> irq_o rises exactly 11 cycles after act. Int pulse plus W1C at cycle 5 -> no irq_o, FSM back to IDLE.
- IMASK=0x00FE, int on port 0 -> IPEND bit0 set, irq_o stays 0. Set IMASK=0x00FF -> irq_o asserts.
- Set and W1C of IPEND[3] in same cycle -> bit remains 1. areset mid-HOLD -> next cycle irq_o=0, IMASK=0xFFFF, state IDLE.
